// File: rtl/sar_search.sv
// Successive-approximation search driving an external magnitude comparator.
// One bit is resolved per cycle from MSB to LSB; an exact match ends the search early.
module sar_search #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [W-1:0] trial,
  input  logic         gt,
  input  logic         lt,
  input  logic         eq,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         hit,
  output logic         err
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    TEST = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [KW-1:0] k, k_n;
  logic [W-1:0]  trial_n, result_n, probe;
  logic          hit_n, err_n, done_n, flags_ok;

  assign busy     = (state == TEST);
  // Exactly one comparator flag must be asserted; anything else is a broken comparator.
  assign flags_ok = ({lt, gt, eq} inside {3'b100, 3'b010, 3'b001});

  always_comb begin
    state_n  = state;
    trial_n  = trial;
    k_n      = k;
    result_n = result;
    hit_n    = hit;
    err_n    = err;
    done_n   = 1'b0;
    probe    = trial;
    unique case (state)
      IDLE: begin
        if (start) begin
          trial_n  = W'(1) << (W - 1);
          k_n      = KW'(W - 1);
          result_n = '0;
          hit_n    = 1'b0;
          err_n    = 1'b0;
          state_n  = TEST;
        end
      end
      TEST: begin
        if (!flags_ok) begin
          err_n    = 1'b1;
          result_n = '0;
          hit_n    = 1'b0;
          done_n   = 1'b1;
          state_n  = IDLE;
        end else if (eq) begin
          result_n = trial;
          hit_n    = 1'b1;
          done_n   = 1'b1;
          state_n  = IDLE;
        end else begin
          // Target below trial: bit k was too much; otherwise keep it.
          if (lt) probe[k] = 1'b0;
          if (k != '0) begin
            probe[k - KW'(1)] = 1'b1;
            k_n               = k - KW'(1);
          end else begin
            result_n = probe;
            hit_n    = 1'b0;
            done_n   = 1'b1;
            state_n  = IDLE;
          end
          trial_n = probe;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      trial  <= '0;
      k      <= '0;
      result <= '0;
      hit    <= 1'b0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      trial  <= trial_n;
      k      <= k_n;
      result <= result_n;
      hit    <= hit_n;
      err    <= err_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: comparator modelled from a target register, expected
// trial sequence and outcome computed by an arithmetic binary-search model.
module tb_sar_search;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] trial, result;
  logic         gt, lt, eq, busy, done, hit, err;
  logic [W-1:0] target = '0;
  logic         force_bad = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_res;
  logic         exp_hit;

  always #5 clk = ~clk;

  assign gt = force_bad | (target > trial);
  assign lt = force_bad | (target < trial);
  assign eq = !force_bad && (target == trial);

  sar_search #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .trial(trial),
    .gt(gt), .lt(lt), .eq(eq), .busy(busy), .done(done),
    .result(result), .hit(hit), .err(err)
  );

  // Binary search by halving step weights: test t, step down on lt, add next weight.
  function automatic void build_model(input int tgt);
    int w, t;
    exp_q.delete();
    w = 1 << (W - 1);
    t = w;
    exp_hit = 1'b0;
    exp_res = '0;
    while (1) begin
      exp_q.push_back(W'(t));
      if (tgt == t) begin
        exp_hit = 1'b1;
        exp_res = W'(t);
        break;
      end
      if (tgt < t) t = t - w;
      w = w / 2;
      if (w == 0) begin
        exp_res = W'(t);
        break;
      end
      t = t + w;
    end
  endfunction

  // Pulses start (or leaves it held), walks every expected test cycle, ends in the done cycle.
  task automatic run_search(input int tgt, input bit poke, input bit hold);
    build_model(tgt);
    target = W'(tgt);
    start  = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (trial !== exp_q[i] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL search_step tgt=%0d i=%0d: trial=%0d busy=%b done=%b, want trial=%0d busy=1 done=0",
                 tgt, i, trial, busy, done, exp_q[i]);
      end
      if (i == 0) begin
        checks++;
        if (result !== '0 || hit !== 1'b0 || err !== 1'b0) begin
          errors++;
          $display("FAIL start_clear tgt=%0d: result=%0d hit=%b err=%b, want 0 0 0", tgt, result, hit, err);
        end
      end
      if (poke && !hold) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== exp_res || hit !== exp_hit || err !== 1'b0) begin
      errors++;
      $display("FAIL search_done tgt=%0d: done=%b busy=%b result=%0d hit=%b err=%b, want 1 0 %0d %b 0",
               tgt, done, busy, result, hit, err, exp_res, exp_hit);
    end
  endtask

  task automatic check_hold(input string name);
    logic [W-1:0] last_trial;
    last_trial = exp_q[exp_q.size() - 1];
    if (!exp_hit && exp_res != last_trial) last_trial = exp_res;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res || hit !== exp_hit || trial !== last_trial) begin
      errors++;
      $display("FAIL %s: done=%b busy=%b result=%0d hit=%b trial=%0d, want 0 0 %0d %b %0d",
               name, done, busy, result, hit, trial, exp_res, exp_hit, last_trial);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (trial !== '0 || busy !== 1'b0 || done !== 1'b0 || result !== '0 || hit !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: trial=%0d busy=%b done=%b result=%0d hit=%b err=%b, want all 0",
               trial, busy, done, result, hit, err);
    end
    #10 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || trial !== '0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: busy=%b trial=%0d done=%b, want 0 0 0", busy, trial, done);
      end
    end
  endtask

  task automatic test_directed();
    run_search(11, 1'b0, 1'b0);
    check_hold("hold_11");
    run_search(8, 1'b0, 1'b0);
    check_hold("hold_8");
    run_search(0, 1'b0, 1'b0);
    check_hold("hold_0");
  endtask

  task automatic test_hold_start();
    bit got;
    run_search(15, 1'b0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (trial !== W'(8) || busy !== 1'b1 || done !== 1'b0 || result !== '0 || hit !== 1'b0) begin
      errors++;
      $display("FAIL hold_restart: trial=%0d busy=%b done=%b result=%0d hit=%b, want 8 1 0 0 0",
               trial, busy, done, result, hit);
    end
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || result !== W'(15) || hit !== 1'b1) begin
      errors++;
      $display("FAIL hold_second: done_seen=%b result=%0d hit=%b, want 1 15 1", got, result, hit);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int tgt;
    do tgt = $urandom_range(0, 15); while (tgt == 8);
    target = W'(tgt);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (trial !== W'(8) || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_first: trial=%0d busy=%b, want 8 1", trial, busy);
    end
    @(posedge clk); #1;
    force_bad = 1'b1;
    @(posedge clk); #1;
    force_bad = 1'b0;
    checks++;
    if (err !== 1'b1 || result !== '0 || hit !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_done: err=%b result=%0d hit=%b done=%b busy=%b, want 1 0 0 1 0",
               err, result, hit, done, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold: err=%b done=%b busy=%b, want 1 0 0", err, done, busy);
    end
    run_search($urandom_range(0, 15), 1'b0, 1'b0);
    check_hold("abort_recover");
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      run_search($urandom_range(0, 15), 1'b1, 1'b0);
      check_hold("random_hold");
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) run_search($urandom_range(0, 15), 1'b0, 1'b0);
    check_hold("b2b_hold");
  endtask

  task automatic test_reset_mid();
    int tgt;
    do begin
      tgt = $urandom_range(0, 15);
      build_model(tgt);
    end while (exp_q.size() < 3);
    target = W'(tgt);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || trial !== exp_q[2]) begin
      errors++;
      $display("FAIL mid_third: busy=%b trial=%0d, want 1 %0d", busy, trial, exp_q[2]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (trial !== '0 || busy !== 1'b0 || done !== 1'b0 || result !== '0 || hit !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: trial=%0d busy=%b done=%b result=%0d hit=%b err=%b, want all 0",
               trial, busy, done, result, hit, err);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || trial !== '0 || done !== 1'b0) begin
        errors++;
        $display("FAIL mid_idle: busy=%b trial=%0d done=%b, want 0 0 0", busy, trial, done);
      end
    end
    run_search(tgt, 1'b1, 1'b0);
    check_hold("mid_recover");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_start();
    test_abort();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
